// File: rtl/nn_host_bridge.sv
// Host-side bus adapter for the accelerator memory-mapped port.
// Host writes to accelerator space are buffered in a small FIFO that drains
// whenever the accelerator is not busy. Host reads go through a fixed
// three-stage pipeline to either the accelerator output memory or the
// bridge CSRs (status, write count, read count).
module nn_host_bridge #(
  parameter int MM_DEPTH    = 16,
  parameter int MM_SIZE     = 32,
  parameter int Q_SIZE      = 16,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MM_DEPTH:0]   address,
  input  logic                write,
  input  logic [MM_SIZE-1:0]  writedata,
  input  logic                read,
  output logic                waitrequest,
  output logic [MM_SIZE-1:0]  readdata,
  output logic                readdatavalid,
  output logic                nn_write_enable,
  output logic [MM_DEPTH-1:0] nn_write_addr,
  output logic [MM_SIZE-1:0]  nn_write_data,
  input  logic                nn_busy,
  output logic [MM_DEPTH-1:0] nn_read_addr,
  input  logic [Q_SIZE-1:0]   nn_read_data
);

  localparam int QN = 1 << QUEUE_DEPTH;
  localparam int QW = MM_DEPTH + MM_SIZE;

  logic [QW-1:0]          q_mem [QN];
  logic [QUEUE_DEPTH-1:0] wr_ptr;
  logic [QUEUE_DEPTH-1:0] rd_ptr;
  logic [QUEUE_DEPTH:0]   q_level;
  logic                   q_empty;
  logic                   q_full;
  logic                   push;
  logic                   pop;
  logic                   csr_sel;
  logic                   rd_acc;
  logic                   wr_clr;
  logic                   rd_clr;

  logic                   s1_vld;
  logic                   s1_csr;
  logic [1:0]             s1_sel;
  logic                   s2_vld;
  logic                   s2_csr;
  logic [1:0]             s2_sel;
  logic [MM_SIZE-1:0]     csr_rdata;
  logic [31:0]            wr_count;
  logic [31:0]            rd_count;

  assign csr_sel     = address[MM_DEPTH];
  assign q_empty     = (q_level == '0);
  assign q_full      = (q_level == (QUEUE_DEPTH+1)'(QN));
  // Stall depends only on full, so a push is refused even when a pop frees a slot.
  assign waitrequest = write & ~csr_sel & q_full;
  assign push        = write & ~csr_sel & ~q_full;
  assign nn_write_enable = ~q_empty & ~nn_busy;
  assign pop         = nn_write_enable;
  // Head is forced to zero when empty so the strobe bus is quiet after reset.
  assign {nn_write_addr, nn_write_data} = q_empty ? '0 : q_mem[rd_ptr];

  // A read together with a write is a protocol error: the read is dropped.
  assign rd_acc = read & ~write;
  assign wr_clr = write & csr_sel & (address[1:0] == 2'd1);
  assign rd_clr = write & csr_sel & (address[1:0] == 2'd2);

  // Queue storage; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= {address[MM_DEPTH-1:0], writedata};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_level <= q_level + 1'b1;
        2'b01:   q_level <= q_level - 1'b1;
        default: q_level <= q_level;
      endcase
    end
  end

  // CSR read mux, sampled in the last pipeline stage.
  always_comb begin
    csr_rdata = '0;
    case (s2_sel)
      2'd0: begin
        csr_rdata[0]                 = nn_busy;
        csr_rdata[1]                 = q_empty;
        csr_rdata[2]                 = q_full;
        csr_rdata[QUEUE_DEPTH+3:3]   = q_level;
      end
      2'd1:    csr_rdata = MM_SIZE'(wr_count);
      2'd2:    csr_rdata = MM_SIZE'(rd_count);
      default: csr_rdata = '0;
    endcase
  end

  // Read pipeline: address stage, accelerator memory stage, data return stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_vld        <= 1'b0;
      s1_csr        <= 1'b0;
      s1_sel        <= '0;
      s2_vld        <= 1'b0;
      s2_csr        <= 1'b0;
      s2_sel        <= '0;
      nn_read_addr  <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      s1_vld <= rd_acc;
      s1_csr <= csr_sel;
      s1_sel <= address[1:0];
      if (rd_acc & ~csr_sel) nn_read_addr <= address[MM_DEPTH-1:0];
      s2_vld <= s1_vld;
      s2_csr <= s1_csr;
      s2_sel <= s1_sel;
      readdatavalid <= s2_vld;
      if (s2_vld) readdata <= s2_csr ? csr_rdata : MM_SIZE'(nn_read_data);
    end
  end

  // Event counters; a clear on the same edge as a count event wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_clr)   wr_count <= '0;
      else if (pop) wr_count <= wr_count + 32'd1;
      if (rd_clr)                  rd_count <= '0;
      else if (rd_acc & ~csr_sel)  rd_count <= rd_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_nn_host_bridge.sv
// Scoreboard bench for nn_host_bridge: a queue-based reference model predicts
// accelerator writes, stalls and read responses; a monitor compares on the
// falling edge.
module tb_nn_host_bridge;

  localparam int QN = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [16:0] address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic        nn_busy = 1'b0;
  logic [15:0] nn_read_data = '0;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        nn_write_enable;
  logic [15:0] nn_write_addr;
  logic [31:0] nn_write_data;
  logic [15:0] nn_read_addr;

  nn_host_bridge #(.MM_DEPTH(16), .MM_SIZE(32), .Q_SIZE(16), .QUEUE_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .nn_write_enable(nn_write_enable), .nn_write_addr(nn_write_addr),
    .nn_write_data(nn_write_data), .nn_busy(nn_busy),
    .nn_read_addr(nn_read_addr), .nn_read_data(nn_read_data)
  );

  always #5 clk = ~clk;

  // Accelerator output memory: one-cycle latency, contents 0x8001 + addr.
  always @(posedge clk) nn_read_data <= 16'h8001 + nn_read_addr;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          issued;
    logic        csr;
    logic [1:0]  sel;
    logic [15:0] addr;
  } rd_t;

  logic [47:0] mq[$];
  rd_t         pipe[$];
  logic [31:0] exp_rd[$];
  logic [31:0] wr_cnt_m = '0;
  logic [31:0] rd_cnt_m = '0;
  int          edge_cnt = 0;
  int          rst_edge = -10;
  bit          live = 1'b0;

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = '0;
    s[0]   = nn_busy;
    s[1]   = (mq.size() == 0);
    s[2]   = (mq.size() == QN);
    s[5:3] = 3'(mq.size());
    return s;
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle.
  always @(posedge clk) begin
    bit          drain;
    bit          full;
    rd_t         r;
    logic [31:0] e;
    edge_cnt++;
    if (!reset) begin
      mq.delete();
      pipe.delete();
      exp_rd.delete();
      wr_cnt_m = '0;
      rd_cnt_m = '0;
      live     = 1'b1;
      rst_edge = edge_cnt;
    end else if (live) begin
      while (pipe.size() > 0 && pipe[0].issued == edge_cnt - 2) begin
        r = pipe.pop_front();
        if (r.csr) begin
          case (r.sel)
            2'd0:    e = status_m();
            2'd1:    e = wr_cnt_m;
            2'd2:    e = rd_cnt_m;
            default: e = '0;
          endcase
        end else begin
          e = {16'h0, 16'(16'h8001 + r.addr)};
        end
        exp_rd.push_back(e);
      end
      full  = (mq.size() == QN);
      drain = (mq.size() != 0) && !nn_busy;
      if (drain) void'(mq.pop_front());
      if (write && !address[16] && !full) mq.push_back({address[15:0], writedata});
      if (write && address[16] && address[1:0] == 2'd1) wr_cnt_m = '0;
      else if (drain) wr_cnt_m = wr_cnt_m + 1;
      if (write && address[16] && address[1:0] == 2'd2) rd_cnt_m = '0;
      if (read && !write) begin
        r.issued = edge_cnt;
        r.csr    = address[16];
        r.sel    = address[1:0];
        r.addr   = address[15:0];
        pipe.push_back(r);
        if (!address[16]) rd_cnt_m = rd_cnt_m + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit          exp_we;
    logic [31:0] e;
    if (live) begin
      check("waitrequest", 64'(waitrequest), 64'(write && !address[16] && mq.size() == QN));
      exp_we = (mq.size() != 0) && !nn_busy;
      check("nn_write_enable", 64'(nn_write_enable), 64'(exp_we));
      if (exp_we && nn_write_enable)
        check("nn_write_addr_data", 64'({nn_write_addr, nn_write_data}), 64'(mq[0]));
      if (exp_rd.size() > 0) begin
        e = exp_rd.pop_front();
        check("readdatavalid", 64'(readdatavalid), 64'd1);
        if (readdatavalid) check("readdata", 64'(readdata), 64'(e));
      end else begin
        check("readdatavalid", 64'(readdatavalid), 64'd0);
      end
      if (rst_edge == edge_cnt) begin
        check("reset_rd_regs", 64'({readdata, nn_read_addr}), 64'd0);
        check("reset_wr_bus", 64'({nn_write_addr, nn_write_data}), 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    write = 1'b0;
    read  = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [16:0] a, input logic [31:0] d);
    bit done;
    done      = 1'b0;
    write     = 1'b1;
    read      = 1'b0;
    address   = a;
    writedata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = !waitrequest;
      step();
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL write_accept_timeout: addr %0h not accepted, required acceptance", a);
    end
  endtask

  task automatic rd(input logic [16:0] a);
    write   = 1'b0;
    read    = 1'b1;
    address = a;
    step();
  endtask

  initial begin
    int r;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;

    // Write burst with no back-pressure, then WR_COUNT.
    nn_busy = 1'b0;
    for (int i = 0; i < 8; i++) wr(17'h00010 + 17'(i), 32'hA0 + 32'(i));
    idle(3);
    rd(17'h10001);
    idle(4);

    // Read pipeline, then RD_COUNT.
    rd(17'h00002);
    rd(17'h00003);
    rd(17'h00004);
    idle(4);
    rd(17'h10002);
    idle(4);

    // Back-pressure: four fill the queue, fifth stalls, status shows full.
    nn_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr(17'h00100 + 17'(i), 32'hB0 + 32'(i));
    write = 1'b1; read = 1'b0; address = 17'h00104; writedata = 32'hB4;
    step();
    step();
    rd(17'h10000);
    idle(4);
    nn_busy = 1'b0;
    wr(17'h00104, 32'hB4);
    wr(17'h00105, 32'hB5);
    idle(6);

    // Clear WR_COUNT on the same edge a queued write drains.
    nn_busy = 1'b1;
    wr(17'h00020, 32'h55);
    nn_busy = 1'b0;
    write = 1'b1; read = 1'b0; address = 17'h10001; writedata = 32'h0;
    step();
    wr(17'h00021, 32'h66);
    idle(3);
    rd(17'h10001);
    idle(4);

    // Reset with queued writes and reads in flight.
    nn_busy = 1'b1;
    wr(17'h00030, 32'h1);
    wr(17'h00031, 32'h2);
    wr(17'h00032, 32'h3);
    rd(17'h00002);
    rd(17'h00003);
    read  = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    nn_busy = 1'b0;
    idle(5);
    rd(17'h10000);
    idle(4);

    // Protocol error: read and write together.
    write = 1'b1; read = 1'b1; address = 17'h00005; writedata = 32'hC5;
    step();
    idle(4);
    rd(17'h10002);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset   = 1'b1;
      nn_busy = ($urandom_range(0, 2) == 0);
      write   = 1'b0;
      read    = 1'b0;
      r = $urandom_range(0, 99);
      writedata = $urandom;
      if (r < 35) begin
        write = 1'b1; address = {1'b0, 16'($urandom)};
      end else if (r < 42) begin
        write = 1'b1; address = {1'b1, 14'($urandom), 2'($urandom_range(0, 3))};
      end else if (r < 72) begin
        read = 1'b1; address = {1'b0, 16'($urandom)};
      end else if (r < 84) begin
        read = 1'b1; address = {1'b1, 14'($urandom), 2'($urandom_range(0, 3))};
      end else if (r < 87) begin
        write = 1'b1; read = 1'b1; address = {1'($urandom_range(0, 1)), 16'($urandom)};
      end else if (r == 87) begin
        reset = 1'b0;
      end
      step();
    end
    reset   = 1'b1;
    nn_busy = 1'b0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
